// File: rtl/fb_rect_painter_pkg.sv
// Shared constants, state encoding and command payload for the rectangle painter.
package fb_rect_painter_pkg;

   localparam int unsigned SCREEN_X = 265;
   localparam int unsigned SCREEN_Y = 265;
   localparam int unsigned AW       = 17;
   localparam int unsigned DW       = 3;
   localparam int unsigned CW       = 9;   // command coordinate width
   localparam int unsigned EW       = 10;  // clipped end-coordinate width (x+w never overflows)

   localparam logic [DW-1:0] COLOR_RED   = 3'b100;
   localparam logic [DW-1:0] COLOR_GREEN = 3'b010;
   localparam logic [DW-1:0] COLOR_BLUE  = 3'b001;
   localparam logic [DW-1:0] COLOR_BLACK = 3'b000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CLIP = 2'd1,
      ST_DRAW = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   typedef struct packed {
      logic [CW-1:0] x;
      logic [CW-1:0] y;
      logic [CW-1:0] w;
      logic [CW-1:0] h;
      logic [DW-1:0] color;
   } rect_cmd_t;

   // Exclusive end coordinate of a span, clipped to the screen edge.
   function automatic logic [EW-1:0] clip_end(input logic [CW-1:0] org,
                                              input logic [CW-1:0] len,
                                              input logic [EW-1:0] lim);
      logic [EW-1:0] sum;
      sum = EW'(org) + EW'(len);
      return (sum > lim) ? lim : sum;
   endfunction

endpackage

// File: rtl/fb_rect_painter.sv
// Rectangle-fill write engine: accepts one command, clips it, emits one RAM write per clock.
module fb_rect_painter
   import fb_rect_painter_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic [CW-1:0] cmd_x,
   input  logic [CW-1:0] cmd_y,
   input  logic [CW-1:0] cmd_w,
   input  logic [CW-1:0] cmd_h,
   input  logic [DW-1:0] cmd_color,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   output logic [AW-1:0] mem_px_addr,
   output logic [DW-1:0] mem_px_data,
   output logic          px_wr,
   output logic          busy,
   output logic          done
);

   state_t        r_state,    w_state_nx;
   rect_cmd_t     r_cmd,      w_cmd_nx;
   logic [EW-1:0] r_x_end,    w_x_end_nx;
   logic [EW-1:0] r_y_end,    w_y_end_nx;
   logic [CW-1:0] r_cx,       w_cx_nx;
   logic [CW-1:0] r_cy,       w_cy_nx;
   logic [AW-1:0] r_row_base, w_row_base_nx;
   logic          r_ready,    w_ready_nx;
   logic          r_busy,     w_busy_nx;
   logic          r_done,     w_done_nx;
   logic          r_px_wr,    w_px_wr_nx;
   logic [AW-1:0] r_addr,     w_addr_nx;
   logic [DW-1:0] r_data,     w_data_nx;

   logic [EW-1:0] w_x_end;
   logic [EW-1:0] w_y_end;
   logic [AW-1:0] w_row0;
   logic [EW-1:0] w_cx_inc;
   logic          w_last_col;
   logic          w_last_row;
   logic [AW-1:0] w_row_next;
   logic          w_empty;

   // Clip bounds and first-row base; the multiply feeds registers only in CLIP.
   assign w_x_end    = clip_end(r_cmd.x, r_cmd.w, EW'(SCREEN_X));
   assign w_y_end    = clip_end(r_cmd.y, r_cmd.h, EW'(SCREEN_Y));
   assign w_row0     = AW'(r_cmd.y) * AW'(SCREEN_X);
   assign w_empty    = (r_cmd.w == '0) || (r_cmd.h == '0) ||
                       (EW'(r_cmd.x) >= EW'(SCREEN_X)) || (EW'(r_cmd.y) >= EW'(SCREEN_Y));

   // Raster-walk helpers used while drawing (adders only).
   assign w_cx_inc   = EW'(r_cx) + EW'(1);
   assign w_last_col = !(w_cx_inc < r_x_end);
   assign w_last_row = ((EW'(r_cy) + EW'(1)) == r_y_end);
   assign w_row_next = r_row_base + AW'(SCREEN_X);

   // Next-state and next-output logic; outputs are registered from these values.
   always_comb begin
      w_state_nx    = r_state;
      w_cmd_nx      = r_cmd;
      w_x_end_nx    = r_x_end;
      w_y_end_nx    = r_y_end;
      w_cx_nx       = r_cx;
      w_cy_nx       = r_cy;
      w_row_base_nx = r_row_base;
      w_ready_nx    = r_ready;
      w_busy_nx     = r_busy;
      w_done_nx     = 1'b0;
      w_px_wr_nx    = 1'b0;
      w_addr_nx     = r_addr;
      w_data_nx     = r_data;

      case (r_state)
         ST_IDLE: begin
            if (cmd_valid) begin
               w_cmd_nx.x     = cmd_x;
               w_cmd_nx.y     = cmd_y;
               w_cmd_nx.w     = cmd_w;
               w_cmd_nx.h     = cmd_h;
               w_cmd_nx.color = cmd_color;
               w_state_nx     = ST_CLIP;
               w_ready_nx     = 1'b0;
               w_busy_nx      = 1'b1;
            end
         end
         ST_CLIP: begin
            w_x_end_nx    = w_x_end;
            w_y_end_nx    = w_y_end;
            w_row_base_nx = w_row0;
            if (w_empty) begin
               w_state_nx = ST_DONE;
               w_done_nx  = 1'b1;
            end else begin
               w_cx_nx    = r_cmd.x;
               w_cy_nx    = r_cmd.y;
               w_state_nx = ST_DRAW;
               w_px_wr_nx = 1'b1;
               w_addr_nx  = w_row0 + AW'(r_cmd.x);
               w_data_nx  = r_cmd.color;
            end
         end
         ST_DRAW: begin
            if (!w_last_col) begin
               w_cx_nx    = CW'(w_cx_inc);
               w_px_wr_nx = 1'b1;
               w_addr_nx  = r_row_base + AW'(w_cx_inc);
            end else if (w_last_row) begin
               w_state_nx = ST_DONE;
               w_done_nx  = 1'b1;
            end else begin
               w_cx_nx       = r_cmd.x;
               w_cy_nx       = r_cy + CW'(1);
               w_row_base_nx = w_row_next;
               w_px_wr_nx    = 1'b1;
               w_addr_nx     = w_row_next + AW'(r_cmd.x);
            end
         end
         ST_DONE: begin
            w_state_nx = ST_IDLE;
            w_ready_nx = 1'b1;
            w_busy_nx  = 1'b0;
         end
         default: begin
            w_state_nx = ST_IDLE;
            w_ready_nx = 1'b1;
            w_busy_nx  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset kills any pending write immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_IDLE;
         r_cmd      <= '0;
         r_x_end    <= '0;
         r_y_end    <= '0;
         r_cx       <= '0;
         r_cy       <= '0;
         r_row_base <= '0;
         r_ready    <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_px_wr    <= 1'b0;
         r_addr     <= '0;
         r_data     <= '0;
      end else begin
         r_state    <= w_state_nx;
         r_cmd      <= w_cmd_nx;
         r_x_end    <= w_x_end_nx;
         r_y_end    <= w_y_end_nx;
         r_cx       <= w_cx_nx;
         r_cy       <= w_cy_nx;
         r_row_base <= w_row_base_nx;
         r_ready    <= w_ready_nx;
         r_busy     <= w_busy_nx;
         r_done     <= w_done_nx;
         r_px_wr    <= w_px_wr_nx;
         r_addr     <= w_addr_nx;
         r_data     <= w_data_nx;
      end
   end

   assign cmd_ready   = r_ready;
   assign busy        = r_busy;
   assign done        = r_done;
   assign px_wr       = r_px_wr;
   assign mem_px_addr = r_addr;
   assign mem_px_data = r_data;

endmodule
